// File: rtl/match_round_controller.sv
// Round/match sequencer for a best-of-N fight: reloads health, runs the countdown and
// round clock, gates attacks, scores KOs and timeouts and declares the match winner.
//
// state      | meaning
// S_IDLE     | waiting for a start edge, all outputs 0
// S_LOAD     | one cycle, health_reset pulsed
// S_COUNT    | pre-fight countdown, sec_count shows seconds left
// S_FIGHT    | attacks enabled, round clock running, KO/timeout watched
// S_REND     | post-round display hold
// S_OVER     | match decided, outputs frozen until a start edge
module match_round_controller #(
   parameter int CLK_HZ            = 100_000_000,
   parameter int COUNTDOWN_SECONDS = 3,
   parameter int ROUND_SECONDS     = 60,
   parameter int KO_HOLD_SECONDS   = 2,
   parameter int ROUNDS_TO_WIN     = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [8:0] health_1,
   input  logic [8:0] health_2,
   output logic       health_reset,
   output logic       fight_enable,
   output logic [2:0] phase,
   output logic [6:0] sec_count,
   output logic [2:0] round_num,
   output logic [1:0] p1_rounds,
   output logic [1:0] p2_rounds,
   output logic [1:0] round_winner,
   output logic [1:0] match_winner
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_COUNT = 3'd2,
      S_FIGHT = 3'd3,
      S_REND  = 3'd4,
      S_OVER  = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          start_q;
   logic [6:0]    sec_q, sec_d;
   logic [6:0]    hold_q, hold_d;
   logic [2:0]    round_q, round_d;
   logic [1:0]    p1_q, p1_d, p2_q, p2_d;
   logic [1:0]    rw_q, rw_d, mw_q, mw_d;
   logic          hrst_q, hrst_d;
   logic          fen_q, fen_d;

   logic          start_rise, sec_tick, round_done;
   logic [1:0]    win;

   // Down-counter equivalent of a 0..CLK_HZ-1 prescaler; reloaded on every phase entry.
   assign sec_tick   = (presc_q == '0);
   assign start_rise = start & ~start_q;

   always_comb begin
      state_d    = state_q;
      sec_d      = sec_q;
      hold_d     = hold_q;
      round_d    = round_q;
      p1_d       = p1_q;
      p2_d       = p2_q;
      rw_d       = rw_q;
      mw_d       = mw_q;
      fen_d      = fen_q;
      hrst_d     = 1'b0;
      round_done = 1'b0;
      win        = 2'b00;

      case (state_q)
         S_IDLE, S_OVER: begin
            if (start_rise) begin
               state_d = S_LOAD;
               hrst_d  = 1'b1;
               p1_d    = 2'd0;
               p2_d    = 2'd0;
               rw_d    = 2'b00;
               mw_d    = 2'b00;
               round_d = 3'd1;
               sec_d   = 7'd0;
            end
         end
         S_LOAD: begin
            state_d = S_COUNT;
            sec_d   = 7'(COUNTDOWN_SECONDS);
         end
         S_COUNT: begin
            if (sec_tick) begin
               if (sec_q == 7'd1) begin
                  state_d = S_FIGHT;
                  sec_d   = 7'(ROUND_SECONDS);
                  fen_d   = 1'b1;
               end else begin
                  sec_d = sec_q - 7'd1;
               end
            end
         end
         S_FIGHT: begin
            // KO checks come before the timeout so a KO on the final tick still counts as a KO.
            if (health_1 == 9'd0 && health_2 == 9'd0) begin
               round_done = 1'b1;
            end else if (health_2 == 9'd0) begin
               round_done = 1'b1;
               win        = 2'b01;
            end else if (health_1 == 9'd0) begin
               round_done = 1'b1;
               win        = 2'b10;
            end else if (sec_tick && sec_q == 7'd1) begin
               round_done = 1'b1;
               if (health_1 > health_2)      win = 2'b01;
               else if (health_2 > health_1) win = 2'b10;
            end else if (sec_tick) begin
               sec_d = sec_q - 7'd1;
            end

            if (round_done) begin
               state_d = S_REND;
               fen_d   = 1'b0;
               sec_d   = 7'd0;
               hold_d  = 7'(KO_HOLD_SECONDS);
               rw_d    = win;
               if (win == 2'b01 && p1_q != 2'd3) p1_d = p1_q + 2'd1;
               if (win == 2'b10 && p2_q != 2'd3) p2_d = p2_q + 2'd1;
            end
         end
         S_REND: begin
            if (sec_tick) begin
               if (hold_q == 7'd1) begin
                  if (p1_q == 2'(ROUNDS_TO_WIN)) begin
                     state_d = S_OVER;
                     mw_d    = 2'b01;
                  end else if (p2_q == 2'(ROUNDS_TO_WIN)) begin
                     state_d = S_OVER;
                     mw_d    = 2'b10;
                  end else begin
                     state_d = S_LOAD;
                     hrst_d  = 1'b1;
                     if (round_q != 3'd7) round_d = round_q + 3'd1;
                  end
               end else begin
                  hold_d = hold_q - 7'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q || sec_tick) presc_d = PW'(CLK_HZ - 1);
      else                                presc_d = presc_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         presc_q <= PW'(CLK_HZ - 1);
         sec_q   <= 7'd0;
         hold_q  <= 7'd0;
         round_q <= 3'd0;
         p1_q    <= 2'd0;
         p2_q    <= 2'd0;
         rw_q    <= 2'b00;
         mw_q    <= 2'b00;
         hrst_q  <= 1'b0;
         fen_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         sec_q   <= sec_d;
         hold_q  <= hold_d;
         round_q <= round_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         rw_q    <= rw_d;
         mw_q    <= mw_d;
         hrst_q  <= hrst_d;
         fen_q   <= fen_d;
      end
   end

   // Edge register keeps tracking through reset so a button held across reset cannot start a match.
   always_ff @(posedge clk) begin
      start_q <= start;
   end

   assign phase        = state_q;
   assign health_reset = hrst_q;
   assign fight_enable = fen_q;
   assign sec_count    = sec_q;
   assign round_num    = round_q;
   assign p1_rounds    = p1_q;
   assign p2_rounds    = p2_q;
   assign round_winner = rw_q;
   assign match_winner = mw_q;

endmodule

// File: tb/tb_match_round_controller.sv
// Directed bench for match_round_controller with small timing parameters and
// hand-computed expectations checked by immediate assertions.
module tb_match_round_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [8:0] health_1, health_2;
   logic       health_reset, fight_enable;
   logic [2:0] phase;
   logic [6:0] sec_count;
   logic [2:0] round_num;
   logic [1:0] p1_rounds, p2_rounds, round_winner, match_winner;

   int n_checks = 0;
   int n_fails  = 0;

   match_round_controller #(
      .CLK_HZ(10), .COUNTDOWN_SECONDS(3), .ROUND_SECONDS(5),
      .KO_HOLD_SECONDS(2), .ROUNDS_TO_WIN(2)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .health_1(health_1), .health_2(health_2),
      .health_reset(health_reset), .fight_enable(fight_enable),
      .phase(phase), .sec_count(sec_count), .round_num(round_num),
      .p1_rounds(p1_rounds), .p2_rounds(p2_rounds),
      .round_winner(round_winner), .match_winner(match_winner)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; health_1 = 9'd300; health_2 = 9'd300;
      cyc(3);
      reset = 1'b0;
      cyc(1);
      chk("rst_phase", phase, 0);
      chk("rst_round", round_num, 0);
      chk("rst_hrst", health_reset, 0);
      chk("rst_fen", fight_enable, 0);
      chk("rst_sec", sec_count, 0);
      chk("rst_mw", match_winner, 0);

      // 1: start, load pulse, countdown 3,2,1 at 10 cycles each
      start = 1'b1;
      cyc(1);
      chk("load_phase", phase, 1);
      chk("load_hrst", health_reset, 1);
      chk("load_round", round_num, 1);
      cyc(1);
      chk("cd_phase", phase, 2);
      chk("cd_hrst_off", health_reset, 0);
      chk("cd_sec3", sec_count, 3);
      cyc(9);
      chk("cd_sec3_end", sec_count, 3);
      cyc(1);
      chk("cd_sec2", sec_count, 2);
      cyc(10);
      chk("cd_sec1", sec_count, 1);
      cyc(9);
      chk("cd_sec1_end", phase, 2);
      chk("cd_no_fen", fight_enable, 0);
      cyc(1);
      chk("fight_phase", phase, 3);
      chk("fight_fen", fight_enable, 1);
      chk("fight_sec", sec_count, 5);

      // 2: P1 KO, hold, next round
      health_2 = 9'd0;
      cyc(1);
      chk("ko1_phase", phase, 4);
      chk("ko1_p1", p1_rounds, 1);
      chk("ko1_rw", round_winner, 1);
      chk("ko1_fen", fight_enable, 0);
      chk("ko1_sec", sec_count, 0);
      health_2 = 9'd300;
      cyc(19);
      chk("hold_phase", phase, 4);
      cyc(1);
      chk("r2_phase", phase, 1);
      chk("r2_round", round_num, 2);
      chk("r2_hrst", health_reset, 1);
      cyc(1);
      chk("r2_hrst_off", health_reset, 0);
      chk("r2_cd", phase, 2);

      // 3: second P1 KO ends the match
      cyc(30);
      chk("r2_fight", phase, 3);
      health_2 = 9'd0;
      cyc(1);
      chk("ko2_p1", p1_rounds, 2);
      health_2 = 9'd300;
      cyc(20);
      chk("over_phase", phase, 5);
      chk("over_mw", match_winner, 1);
      cyc(100);
      chk("over_hold_phase", phase, 5);
      chk("over_hold_mw", match_winner, 1);
      chk("over_hold_p1", p1_rounds, 2);
      start = 1'b0;
      cyc(1);
      start = 1'b1;
      cyc(1);
      chk("restart_phase", phase, 1);
      chk("restart_p1", p1_rounds, 0);
      chk("restart_mw", match_winner, 0);
      chk("restart_round", round_num, 1);
      chk("restart_hrst", health_reset, 1);

      // 4: timeout 150/120 gives P1, then 100/100 draw replays
      cyc(31);
      chk("t1_fight", phase, 3);
      health_1 = 9'd150; health_2 = 9'd120;
      cyc(49);
      chk("t1_last_sec", sec_count, 1);
      chk("t1_still_fight", phase, 3);
      cyc(1);
      chk("t1_end", phase, 4);
      chk("t1_p1", p1_rounds, 1);
      chk("t1_rw", round_winner, 1);
      cyc(20);
      chk("t2_load_round", round_num, 2);
      cyc(31);
      chk("t2_fight", phase, 3);
      health_1 = 9'd100; health_2 = 9'd100;
      cyc(50);
      chk("t2_end", phase, 4);
      chk("t2_rw_draw", round_winner, 0);
      chk("t2_p1", p1_rounds, 1);
      chk("t2_p2", p2_rounds, 0);
      cyc(20);
      chk("replay_phase", phase, 1);
      chk("replay_round", round_num, 3);

      // 5: double KO draw, then KO on the final tick
      cyc(31);
      health_1 = 9'd0; health_2 = 9'd0;
      cyc(1);
      chk("dko_phase", phase, 4);
      chk("dko_rw", round_winner, 0);
      chk("dko_p1", p1_rounds, 1);
      chk("dko_p2", p2_rounds, 0);
      health_1 = 9'd200; health_2 = 9'd200;
      cyc(20);
      chk("r4_round", round_num, 4);
      cyc(31);
      chk("r4_fight", phase, 3);
      cyc(49);
      chk("r4_last_sec", sec_count, 1);
      health_1 = 9'd0;
      cyc(1);
      chk("lastko_phase", phase, 4);
      chk("lastko_rw", round_winner, 2);
      chk("lastko_p2", p2_rounds, 1);
      chk("lastko_p1", p1_rounds, 1);
      health_1 = 9'd200;
      cyc(20);
      chk("r5_phase", phase, 1);
      chk("r5_round", round_num, 5);

      // 6: reset during FIGHT, start held through release
      cyc(31);
      chk("r5_fight", phase, 3);
      reset = 1'b1;
      cyc(1);
      chk("mid_rst_phase", phase, 0);
      chk("mid_rst_fen", fight_enable, 0);
      chk("mid_rst_sec", sec_count, 0);
      chk("mid_rst_round", round_num, 0);
      chk("mid_rst_p1", p1_rounds, 0);
      chk("mid_rst_p2", p2_rounds, 0);
      chk("mid_rst_rw", round_winner, 0);
      chk("mid_rst_hrst", health_reset, 0);
      reset = 1'b0;
      cyc(5);
      chk("held_start_idle", phase, 0);
      start = 1'b0;
      cyc(1);
      start = 1'b1;
      cyc(1);
      chk("new_edge_load", phase, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
